// File: rtl/keyboard_pkg.sv
// keyboard_pkg: shared types and widths for the keyboard event queue.
package keyboard_pkg;
  localparam int KEY_CODE_W = 6;
  localparam int CNT_W = 4;
  typedef struct packed {
    logic [5:0] code;
    logic       press;
  } key_event_t;
  typedef enum logic [1:0] {KQ_IDLE, KQ_SAMPLE, KQ_SCAN} kq_state_t;
endpackage

// File: rtl/keyboard_event_queue_if.sv
// keyboard_event_queue_if: valid/ready event handshake towards the consumer.
interface keyboard_event_queue_if;
  import keyboard_pkg::*;
  logic                  evt_valid;
  logic                  evt_ready;
  logic [KEY_CODE_W-1:0] evt_code;
  logic                  evt_press;
  modport master(output evt_valid, evt_code, evt_press, input evt_ready);
  modport slave(input evt_valid, evt_code, evt_press, output evt_ready);
endinterface

// File: rtl/keyboard_event_queue_sync_fifo.sv
// sync_fifo: first-word-fall-through FIFO; pushes into a full FIFO are refused.
module sync_fifo #(
  parameter int WIDTH = 7,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign dout = mem[rd_ptr];
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= din;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
endmodule

// File: rtl/keyboard_event_queue.sv
// keyboard_event_queue: debounces scanned key levels and queues press/release events.
module keyboard_event_queue
  import keyboard_pkg::*;
#(
  parameter int NUM_KEYS = 40,
  parameter int DEBOUNCE_TICKS = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                Clk,
  input  logic                Rst_n,
  input  logic                Tick,
  input  logic [NUM_KEYS-1:0] keysState,
  input  logic                clr_overflow,
  output logic                overflow,
  output logic                busy,
  output logic [NUM_KEYS-1:0] keysStable,
  keyboard_event_queue_if.master evt
);
  localparam logic [KEY_CODE_W-1:0] LAST_KEY = KEY_CODE_W'(NUM_KEYS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_TICKS - 1);
  kq_state_t state;
  logic [NUM_KEYS-1:0] raw_q, stable, reported;
  logic [CNT_W-1:0] cnt [NUM_KEYS];
  logic [KEY_CODE_W-1:0] idx;
  logic pending, push, full, empty;
  logic [$clog2(FIFO_DEPTH):0] count;
  key_event_t din, head;
  assign pending = stable[idx] != reported[idx];
  assign push = state == KQ_SCAN && pending && !full;
  assign din = '{code: idx, press: stable[idx]};
  assign busy = state != KQ_IDLE;
  assign keysStable = stable;
  assign evt.evt_valid = count != '0;
  assign evt.evt_code = empty ? '0 : head.code;
  assign evt.evt_press = empty ? 1'b0 : head.press;
  sync_fifo #(.WIDTH($bits(key_event_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(Clk),
    .rst_n(Rst_n),
    .push(push),
    .pop(evt.evt_valid && evt.evt_ready),
    .din(din),
    .dout(head),
    .full(full),
    .empty(empty),
    .count(count)
  );
  // an unreported change that finds the FIFO full stays pending for the next scan
  always_ff @(posedge Clk or negedge Rst_n)
    if (!Rst_n) begin
      state <= KQ_IDLE;
      raw_q <= '0;
      stable <= '0;
      reported <= '0;
      idx <= '0;
      overflow <= 1'b0;
      for (int k = 0; k < NUM_KEYS; k++) cnt[k] <= '0;
    end else begin
      overflow <= (state == KQ_SCAN && pending && full) || (overflow && !clr_overflow);
      case (state)
        KQ_IDLE: if (Tick) begin
          raw_q <= keysState;
          state <= KQ_SAMPLE;
        end
        KQ_SAMPLE: begin
          for (int k = 0; k < NUM_KEYS; k++)
            if (raw_q[k] == stable[k]) cnt[k] <= '0;
            else if (cnt[k] == CNT_MAX) begin
              stable[k] <= raw_q[k];
              cnt[k] <= '0;
            end else cnt[k] <= cnt[k] + 1'b1;
          idx <= '0;
          state <= KQ_SCAN;
        end
        KQ_SCAN: begin
          if (push) reported[idx] <= stable[idx];
          idx <= idx + 1'b1;
          if (idx == LAST_KEY) state <= KQ_IDLE;
        end
        default: state <= KQ_IDLE;
      endcase
    end
endmodule
